pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
Parametrised, pipelined add/subtract unit. It is the sequential successor to the combinational adder used across the codebase.
- Operands are split into STAGES equal chunks; each pipeline stage adds one chunk and registers the carry into the next stage.
- Valid/ready handshakes on both sides with full backpressure.
- Sits between operand producers and datapath consumers that need WIDTH > 32 at high clock rates.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2 and divisible by STAGES.
- STAGES, 4, number of pipeline stages (≥ 1). Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit accepts the operation this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in; ignored when in_sub=1
- in_sub  input  1  0: A+B+cin; 1: A−B
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- out_s  output  WIDTH  sum/difference, modulo 2^WIDTH
- out_cout  output  1  carry-out; when in_sub=1, 1 = no borrow (A ≥ B unsigned)
- out_ovf  output  1  two's-complement signed overflow

Behaviour:
- Operand transform at acceptance: b_eff = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
- Stage k (0..STAGES−1):
  - computes chunk k of s = a[k] + b_eff[k] + carry_k over CW bits, producing carry_{k+1};
  - carry_0 = c0; the result chunk and carry are registered.
  - Unprocessed upper operand chunks and already-computed lower result chunks travel with the entry.
- Output register = last stage:
  - out_cout = carry_STAGES.
  - out_ovf = (a[W−1] == b_eff[W−1]) && (s[W−1] != a[W−1]).
- Handshake:
  - Each stage has a valid bit; ready_k = ~valid_k | ready_{k+1}; ready_STAGES = out_ready.
  - in_ready = ready_0 is combinational from out_ready through the stage valids.
  - Transfer occurs when valid && ready on the same cycle.
- Latency: an entry accepted at edge N has out_valid high after edge N+STAGES−1 when not stalled (STAGES=1: result registered, visible the cycle after acceptance).
- Throughput: one op/cycle with out_ready held high. Capacity = STAGES entries; stall compression fills bubbles.
- Stall: while out_valid && !out_ready, out_s/out_cout/out_ovf are held stable. Entries are never dropped, duplicated or reordered.
- in_valid without in_ready: no state change; upstream must hold its operands.
- Reset (rst_n low, any time, asynchronous):
  - all stage valids = 0, out_valid = 0;
  - out_s = 0, out_cout = 0, out_ovf = 0, internal data registers = 0;
  - in-flight entries are discarded.
  - in_ready = 1 during and immediately after reset.
- Wrap-around: the sum is modulo 2^WIDTH; the carry leaves only via out_cout.
- Elaboration error if WIDTH % STAGES ≠ 0, STAGES < 1 or WIDTH < 2.

Test Plan:
Configuration for all scenarios: WIDTH=32, STAGES=4.
1. Basic carry: A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0, out_ready=1 → after 4 edges out_valid=1, out_s=0x00000000, out_cout=1, out_ovf=0.
2. Cross-chunk ripple: A=0x00FFFFFF, B=0x00000000, cin=1 → out_s=0x01000000, out_cout=0. Also A=0x7FFFFFFF, B=1, cin=0 → out_s=0x80000000, out_ovf=1.
3. Subtract cases:
   - A=5, B=7, sub=1, cin=1 (ignored) → out_s=0xFFFFFFFE, out_cout=0, out_ovf=0.
   - A=0x80000000, B=1, sub=1 → out_s=0x7FFFFFFF, out_cout=1, out_ovf=1.
4. Streaming: 200 random ops (random sub/cin), in_valid and out_ready always 1 → one result per cycle after 4-cycle fill, in order, each matching a reference model.
5. Backpressure:
   - Stream ops with out_ready=0 for 12 cycles → exactly 4 accepted, then in_ready=0; out_s is stable throughout.
   - Then randomly toggle out_ready → all results drain in order, with no loss or duplication.
6. Reset mid-stream: assert rst_n=0 asynchronously with 3 entries in flight → out_valid=0 and out_s=0 immediately. After release, in_ready=1 and no stale results appear; a new op 3+4 gives out_s=7.

Source files
------------

// File: rtl/pipe_adder_if.sv
// Operand/result stream bundle for pipe_adder: valid/ready on the operand side and on the result side.
// The design takes the slave view and the operand producer / result consumer take the master view.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_s, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_s, out_cout, out_ovf
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: each stage adds one CW-bit chunk and hands its carry to the next stage,
// with per-stage valid bits and a ready chain that fills bubbles while the output is stalled.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic         clk,
  input logic         rst_n,
  pipe_adder_if.slave bus
);

  localparam int CW = WIDTH / STAGES;

  if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_adder: WIDTH must be >= 2 and divisible by STAGES, and STAGES must be >= 1");
  end

  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             valid_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             c_r;

    logic             v_src_s;
    logic             c_src_s;
    logic [WIDTH-1:0] a_src_s;
    logic [WIDTH-1:0] b_src_s;
    logic [WIDTH-1:0] s_src_s;
    logic [WIDTH-1:0] s_next_s;
    logic [CW:0]      chunk_s;
    logic             ready_s;
    logic             ready_next_s;

    // Stage 0 applies the subtract transform; later stages take the entry held by the previous stage.
    if (k == 0) begin : g_head
      assign v_src_s = bus.in_valid;
      assign a_src_s = bus.in_a;
      assign b_src_s = bus.in_sub ? ~bus.in_b : bus.in_b;
      assign c_src_s = bus.in_sub ? 1'b1 : bus.in_cin;
      assign s_src_s = {WIDTH{1'b0}};
    end else begin : g_body
      assign v_src_s = g_stage[k-1].valid_r;
      assign a_src_s = g_stage[k-1].a_r;
      assign b_src_s = g_stage[k-1].b_r;
      assign c_src_s = g_stage[k-1].c_r;
      assign s_src_s = g_stage[k-1].s_r;
    end

    if (k == STAGES - 1) begin : g_tail
      assign ready_next_s = bus.out_ready;
    end else begin : g_mid
      assign ready_next_s = g_stage[k+1].ready_s;
    end

    // An empty stage can always load, so stalled entries collapse onto the bubbles ahead of them.
    assign ready_s = ~valid_r | ready_next_s;
    assign chunk_s = {1'b0, a_src_s[k*CW +: CW]} + {1'b0, b_src_s[k*CW +: CW]} + {{CW{1'b0}}, c_src_s};

    // Merge this stage's result chunk into the partial sum travelling with the entry.
    always_comb begin
      s_next_s                = s_src_s;
      s_next_s[k*CW +: CW]    = chunk_s[CW-1:0];
    end

    // Stage register: advances when downstream has room, data only captured for valid entries.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        a_r     <= {WIDTH{1'b0}};
        b_r     <= {WIDTH{1'b0}};
        s_r     <= {WIDTH{1'b0}};
        c_r     <= 1'b0;
      end else if (ready_s) begin
        valid_r <= v_src_s;
        if (v_src_s) begin
          a_r <= a_src_s;
          b_r <= b_src_s;
          s_r <= s_next_s;
          c_r <= chunk_s[CW];
        end
      end
    end
  end

  // Only the operand sign bits matter once the last chunk is summed.
  logic unused_low_s;
  assign unused_low_s = ^{g_stage[STAGES-1].a_r[WIDTH-2:0], g_stage[STAGES-1].b_r[WIDTH-2:0]};

  assign bus.in_ready  = g_stage[0].ready_s;
  assign bus.out_valid = g_stage[STAGES-1].valid_r;
  assign bus.out_s     = g_stage[STAGES-1].s_r;
  assign bus.out_cout  = g_stage[STAGES-1].c_r;
  assign bus.out_ovf   = ovf_f(g_stage[STAGES-1].a_r[WIDTH-1], g_stage[STAGES-1].b_r[WIDTH-1],
                               g_stage[STAGES-1].s_r[WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=32, STAGES=4): directed carry/subtract vectors, random
// streaming, backpressure with random out_ready, and asynchronous reset in mid-stream.
module tb_pipe_adder;

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  res_t exp_q[$];

  pipe_adder_if #(.WIDTH(32)) bus ();

  pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned/signed arithmetic on the whole operands.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
    res_t        r;
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      sr;
    logic [32:0] u;
    if (sub) begin
      r.s    = a - b;
      r.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      u      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r.s    = u[31:0];
      r.cout = u[32];
      sr     = sa + sb + longint'(cin);
    end
    r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  // One clock: observe both handshakes just before the edge, then return at posedge+1.
  task automatic step(output logic acc, output logic fired, output res_t r);
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
    fired  = bus.out_valid && bus.out_ready;
    r.s    = bus.out_s;
    r.cout = bus.out_cout;
    r.ovf  = bus.out_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic new_op();
    bus.in_a   = $urandom();
    bus.in_b   = $urandom();
    if ($urandom_range(0, 7) == 0) bus.in_b = ~bus.in_a;
    bus.in_cin   = 1'($urandom_range(0, 1));
    bus.in_sub   = 1'($urandom_range(0, 1));
    bus.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_s !== 32'd0 ||
        bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b vld=%b s=%h c=%b o=%b, expected rdy=1 vld=0 s=0 c=0 o=0",
               bus.in_ready, bus.out_valid, bus.out_s, bus.out_cout, bus.out_ovf);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%b vld=%b, expected rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    vec_t v[7];
    logic acc, fired;
    res_t r;
    v[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    v[1] = '{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0};
    v[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    v[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    v[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    v[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    v[6] = '{32'h12345678, 32'h12345678, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_a     = v[i].a;
      bus.in_b     = v[i].b;
      bus.in_cin   = v[i].cin;
      bus.in_sub   = v[i].sub;
      bus.in_valid = 1'b1;
      step(acc, fired, r);
      bus.in_valid = 1'b0;
      n_cmp++;
      if (acc !== 1'b1) begin
        n_bad++;
        $display("FAIL dir_accept[%0d]: accepted=%b, expected 1", i, acc);
      end
      for (int e = 1; e <= 4; e++) begin
        step(acc, fired, r);
        n_cmp++;
        if (fired !== (e == 4)) begin
          n_bad++;
          $display("FAIL dir_latency[%0d]: out_valid=%b after %0d edges, expected %b", i, fired, e, (e == 4));
        end
        if (e == 4) begin
          n_cmp++;
          if (r.s !== v[i].s || r.cout !== v[i].cout || r.ovf !== v[i].ovf) begin
            n_bad++;
            $display("FAIL dir_result[%0d]: s=%h c=%b o=%b, expected s=%h c=%b o=%b",
                     i, r.s, r.cout, r.ovf, v[i].s, v[i].cout, v[i].ovf);
          end
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic test_stream();
    int   sent = 0, got = 0, first = -1;
    logic acc, fired;
    res_t r, e;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 200; cyc++) begin
      if (sent < 200) new_op();
      else bus.in_valid = 1'b0;
      step(acc, fired, r);
      if (acc) sent++;
      if (fired) begin
        if (first < 0) first = cyc;
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL stream_extra: result %h with nothing pending, expected no result", r.s);
        end else begin
          e = exp_q.pop_front();
          if (r !== e) begin
            n_bad++;
            $display("FAIL stream_result[%0d]: s=%h c=%b o=%b, expected s=%h c=%b o=%b",
                     got, r.s, r.cout, r.ovf, e.s, e.cout, e.ovf);
          end
        end
      end else if (first >= 0 && got < 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_bubble: no result at cycle %0d, expected one per cycle", cyc);
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (sent != 200 || got != 200 || first != 4) begin
      n_bad++;
      $display("FAIL stream_count: sent=%0d got=%0d first=%0d, expected 200/200/4", sent, got, first);
    end
  endtask

  task automatic test_backpressure();
    int   acc_n = 0, got = 0;
    logic acc, fired, stalled, have_hold = 1'b0;
    res_t r, e, hold;
    bus.out_ready = 1'b0;
    new_op();
    for (int c = 0; c < 12; c++) begin
      step(acc, fired, r);
      if (acc) begin
        acc_n++;
        new_op();
      end
      if (bus.out_valid) begin
        if (!have_hold) begin
          hold      = '{bus.out_s, bus.out_cout, bus.out_ovf};
          have_hold = 1'b1;
        end else begin
          n_cmp++;
          if (bus.out_s !== hold.s || bus.out_cout !== hold.cout || bus.out_ovf !== hold.ovf) begin
            n_bad++;
            $display("FAIL bp_stable: s=%h while stalled, expected %h", bus.out_s, hold.s);
          end
        end
      end
    end
    n_cmp++;
    if (acc_n != 4 || bus.in_ready !== 1'b0 || !have_hold) begin
      n_bad++;
      $display("FAIL bp_fill: accepted=%0d in_ready=%b out_seen=%b, expected 4/0/1", acc_n, bus.in_ready, have_hold);
    end
    for (int c = 0; c < 800 && !(acc_n >= 34 && exp_q.size() == 0); c++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      stalled = bus.out_valid && !bus.out_ready;
      hold    = '{bus.out_s, bus.out_cout, bus.out_ovf};
      if (acc_n >= 34) bus.in_valid = 1'b0;
      step(acc, fired, r);
      if (acc) begin
        acc_n++;
        if (acc_n < 34) new_op();
        else bus.in_valid = 1'b0;
      end
      if (stalled) begin
        n_cmp++;
        if (r !== hold || bus.out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_hold: s=%h vld=%b, expected s=%h vld=1", r.s, bus.out_valid, hold.s);
        end
      end
      if (fired) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_extra: result %h with nothing pending, expected no result", r.s);
        end else begin
          e = exp_q.pop_front();
          if (r !== e) begin
            n_bad++;
            $display("FAIL bp_result[%0d]: s=%h c=%b o=%b, expected s=%h c=%b o=%b",
                     got, r.s, r.cout, r.ovf, e.s, e.cout, e.ovf);
          end
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_cmp++;
    if (got != 34 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_drain: results=%0d pending=%0d, expected 34/0", got, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int   got = 0, at = -1;
    logic acc, fired;
    res_t r;
    bus.out_ready = 1'b0;
    new_op();
    for (int c = 0; c < 3; c++) begin
      step(acc, fired, r);
      if (acc) new_op();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_s !== 32'd0 || bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid: vld=%b s=%h rdy=%b, expected vld=0 s=0 rdy=1", bus.out_valid, bus.out_s, bus.in_ready);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_ready: in_ready=%b after release, expected 1", bus.in_ready);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(acc, fired, r);
      n_cmp++;
      if (fired !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_stale: result %h after reset, expected none", r.s);
      end
    end
    bus.in_a = 32'd3; bus.in_b = 32'd4; bus.in_cin = 1'b0; bus.in_sub = 1'b0; bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(acc, fired, r);
      if (acc) bus.in_valid = 1'b0;
      if (fired) begin
        got++;
        at = c;
        n_cmp++;
        if (r.s !== 32'd7 || r.cout !== 1'b0 || r.ovf !== 1'b0) begin
          n_bad++;
          $display("FAIL rst_new_op: s=%h c=%b o=%b, expected s=00000007 c=0 o=0", r.s, r.cout, r.ovf);
        end
      end
    end
    n_cmp++;
    if (got != 1 || at != 4) begin
      n_bad++;
      $display("FAIL rst_new_count: results=%0d at step %0d, expected 1 at step 4", got, at);
    end
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_cin    = 1'b0;
    bus.in_sub    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
